updowncnt_gen: RTL and testbench
================================

# updowncnt_gen

Parametrised bounded up/down counter, the general-purpose successor of the fixed-bound up/down counter in the sequential-logic library. It supports runtime lower/upper bounds, a programmable step, wrap or saturate behaviour, a bounce (ping-pong) mode with an internal direction state, a synchronous clear and a parallel load. It sits wherever a timer, address walker or sweep generator needs a configurable count sequence.

## Interface
- WIDTH, 8, counter, bound and step width in bits (≥2)
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_en  input  1  count enable; one step per enabled cycle
- i_clr  input  1  synchronous clear to i_lo
- i_load  input  1  synchronous parallel load
- i_load_val  input  WIDTH  load value
- i_lo  input  WIDTH  lower bound (inclusive)
- i_hi  input  WIDTH  upper bound (inclusive)
- i_step  input  WIDTH  increment/decrement amount
- i_mode  input  2  0 up, 1 down, 2 bounce, 3 hold
- i_sat  input  1  1 saturate at bound, 0 wrap (ignored in bounce)
- o_cnt  output  WIDTH  registered count
- o_dir  output  1  registered direction, 1 up / 0 down
- o_tc  output  1  terminal-count pulse (only with UDCNT_TC_EN)

## Operation
- Priority per cycle: i_clr > i_load > i_en. i_mode=3 or i_en=0 holds o_cnt; i_clr and i_load still act.
- i_clr: o_cnt←i_lo, o_dir←1.
- i_load: o_cnt←clamp(i_load_val, i_lo, i_hi); o_dir unchanged.
- Boundary compare uses WIDTH+1-bit arithmetic; no silent modulo-2^WIDTH overflow.
- Up (mode 0): if o_cnt+i_step > i_hi, wrap→i_lo or saturate→i_hi; otherwise o_cnt+i_step.
- Down (mode 1): if o_cnt < i_lo+i_step, wrap→i_hi or saturate→i_lo; otherwise o_cnt−i_step.
- Bounce (mode 2), direction FSM with states UP and DOWN:
  - In UP, if o_cnt+i_step ≥ i_hi: o_cnt←i_hi and go to DOWN; otherwise add the step.
  - In DOWN, if o_cnt ≤ i_lo+i_step: o_cnt←i_lo and go to UP; otherwise subtract the step.
- o_dir is forced to 1 in mode 0 and 0 in mode 1 on every cycle, independent of i_en. In modes 2 and 3 it keeps the FSM state.
- Out-of-range count after a runtime bound change: the same compares apply. Up with o_cnt>i_hi takes the wrap/saturate path; down with o_cnt<i_lo likewise.
- i_lo > i_hi (misconfigured): o_cnt and o_dir hold on enabled steps. i_clr and i_load still act; the load clamp result is i_lo.
- i_step = 0: o_cnt holds, no boundary event, o_dir holds in bounce.

## Timing
- Reset values: o_cnt=0, o_dir=1, o_tc=0 (not i_lo).
- All outputs are registered; a step, clear or load is visible one clock after the sampling edge.
- Back-to-back enabled cycles produce one step per cycle with no bubbles.
- Reset asserted mid-sequence clears the outputs immediately. Counting resumes on the first edge after deassertion with o_dir=1.
- Bounds, step and mode are sampled on the same edge as i_en. No shadowing.

## Configuration
- UDCNT_TC_EN defined: o_tc is present.
  - It pulses high for one cycle, aligned with the o_cnt update, after any enabled step that took a wrap, saturate clip or bounce reversal.
  - In a held saturation with i_en high, o_tc re-asserts every cycle.
  - i_clr and i_load never assert o_tc.
- UDCNT_TC_EN undefined: the o_tc port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, lo=3, hi=10, step=3, mode 0, sat 0, from clr → o_cnt 3,6,9,3,6 (o_tc on the third step).
- Same bounds, mode 1, sat 1, load 8 → 5, then 3 held for further cycles; o_tc on the step that reaches 3 and on every held step after it.
- Mode 2, lo=0, hi=7, step=2, from clr → 2,4,6,7,5,3,1,0,2 with o_dir toggling at 7 and 0.
- hi=255, step=200, cnt=100, mode 0, sat 0 → o_cnt=lo (300 > 255 is detected, no 8-bit overflow to 44). Load 300-equivalent clamp check: load_val=250 with hi=200 → o_cnt=200.
- Simultaneous i_clr, i_load and i_en → o_cnt=i_lo, o_dir=1. i_rst pulsed mid-bounce in DOWN → o_cnt=0, o_dir=1 immediately.
- lo=9, hi=4 with i_en high for 5 cycles → o_cnt unchanged, o_tc=0.

Source files
------------

// File: rtl/updowncnt_gen.sv
// Bounded up/down/bounce counter with runtime bounds, step, wrap/saturate, clear and load.
// Optional terminal-count pulse o_tc is built only when UDCNT_TC_EN is defined.
module updowncnt_gen #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_step,
  input  logic [1:0]       i_mode,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_dir
`ifdef UDCNT_TC_EN
  ,
  output logic             o_tc
`endif
);

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DN   = 2'd1;
  localparam logic [1:0] MODE_BNC  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;

  // One extra bit so cnt+step and lo+step never wrap before the bound compare.
  logic [WIDTH:0] cnt_x, lo_x, hi_x, step_x, sum_up, lo_plus;
  logic           up_over, dn_under, bnc_top, bnc_bot;
  logic           bad_cfg, step_ok;
  logic [WIDTH-1:0] load_clamp, cnt_dn;

  assign cnt_x    = {1'b0, cnt_q};
  assign lo_x     = {1'b0, i_lo};
  assign hi_x     = {1'b0, i_hi};
  assign step_x   = {1'b0, i_step};
  assign sum_up   = cnt_x + step_x;
  assign lo_plus  = lo_x + step_x;
  assign up_over  = sum_up > hi_x;
  assign dn_under = cnt_x < lo_plus;
  assign bnc_top  = sum_up >= hi_x;
  assign bnc_bot  = cnt_x <= lo_plus;
  assign cnt_dn   = cnt_q - i_step;
  assign bad_cfg  = i_lo > i_hi;
  assign step_ok  = i_en && (i_mode != MODE_HOLD) && !bad_cfg && (i_step != '0);

  always_comb begin
    load_clamp = i_load_val;
    if (bad_cfg || (i_load_val < i_lo)) begin
      load_clamp = i_lo;
    end else if (i_load_val > i_hi) begin
      load_clamp = i_hi;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (i_mode == MODE_UP) begin
      dir_d = DIR_UP;
    end else if (i_mode == MODE_DN) begin
      dir_d = DIR_DOWN;
    end
    if (i_clr) begin
      cnt_d = i_lo;
      dir_d = DIR_UP;
    end else if (i_load) begin
      cnt_d = load_clamp;
    end else if (step_ok) begin
      case (i_mode)
        MODE_UP:  cnt_d = up_over ? (i_sat ? i_hi : i_lo) : sum_up[WIDTH-1:0];
        MODE_DN:  cnt_d = dn_under ? (i_sat ? i_lo : i_hi) : cnt_dn;
        MODE_BNC: begin
          if (dir_q == DIR_UP) begin
            if (bnc_top) begin
              cnt_d = i_hi;
              dir_d = DIR_DOWN;
            end else begin
              cnt_d = sum_up[WIDTH-1:0];
            end
          end else begin
            if (bnc_bot) begin
              cnt_d = i_lo;
              dir_d = DIR_UP;
            end else begin
              cnt_d = cnt_dn;
            end
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_dir = dir_q;

`ifdef UDCNT_TC_EN
  logic tc_q, tc_d;

  // Flags any enabled step that took a wrap, a saturate clip or a bounce reversal.
  always_comb begin
    tc_d = 1'b0;
    if (!i_clr && !i_load && step_ok) begin
      case (i_mode)
        MODE_UP:  tc_d = up_over;
        MODE_DN:  tc_d = dn_under;
        MODE_BNC: tc_d = (dir_q == DIR_UP) ? bnc_top : bnc_bot;
        default:  tc_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign o_tc = tc_q;
`endif

endmodule

// File: tb/tb_updowncnt_gen.sv
// Bench for updowncnt_gen: directed sequences plus randomized stimulus against an integer model.
// o_tc checks are compiled only when UDCNT_TC_EN is defined.
module tb_updowncnt_gen;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_en = 1'b0;
  logic       i_clr = 1'b0;
  logic       i_load = 1'b0;
  logic [7:0] i_load_val = '0;
  logic [7:0] i_lo = '0;
  logic [7:0] i_hi = '0;
  logic [7:0] i_step = '0;
  logic [1:0] i_mode = '0;
  logic       i_sat = 1'b0;
  logic [7:0] o_cnt;
  logic       o_dir;
`ifdef UDCNT_TC_EN
  logic       o_tc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt = 0;
  bit m_dir = 1'b1;
  bit m_tc  = 1'b0;

  updowncnt_gen #(.WIDTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr), .i_load(i_load),
    .i_load_val(i_load_val), .i_lo(i_lo), .i_hi(i_hi), .i_step(i_step),
    .i_mode(i_mode), .i_sat(i_sat), .o_cnt(o_cnt), .o_dir(o_dir)
`ifdef UDCNT_TC_EN
    , .o_tc(o_tc)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Next-state reference using signed integers, so bound crossings need no extra bit.
  task automatic model_update();
    int lo, hi, st, c, v;
    lo = int'(i_lo); hi = int'(i_hi); st = int'(i_step); c = m_cnt; v = int'(i_load_val);
    m_tc = 1'b0;
    if (i_clr) begin
      m_cnt = lo; m_dir = 1'b1;
      return;
    end
    if (i_mode == 2'd0) m_dir = 1'b1;
    else if (i_mode == 2'd1) m_dir = 1'b0;
    if (i_load) begin
      if (lo > hi || v < lo) m_cnt = lo;
      else if (v > hi) m_cnt = hi;
      else m_cnt = v;
      return;
    end
    if (!i_en || i_mode == 2'd3 || lo > hi || st == 0) return;
    case (i_mode)
      2'd0: if (c + st > hi) begin m_cnt = i_sat ? hi : lo; m_tc = 1'b1; end else m_cnt = c + st;
      2'd1: if (c - st < lo) begin m_cnt = i_sat ? lo : hi; m_tc = 1'b1; end else m_cnt = c - st;
      default: begin
        if (m_dir) begin
          if (c + st >= hi) begin m_cnt = hi; m_dir = 1'b0; m_tc = 1'b1; end else m_cnt = c + st;
        end else begin
          if (c - st <= lo) begin m_cnt = lo; m_dir = 1'b1; m_tc = 1'b1; end else m_cnt = c - st;
        end
      end
    endcase
  endtask

  task automatic tick();
    model_update();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    n_checks++; if (o_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", o_cnt); end
    n_checks++; if (o_dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %0d expected 1", o_dir); end
`ifdef UDCNT_TC_EN
    n_checks++; if (o_tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %0d expected 0", o_tc); end
`endif
    i_rst = 1'b0;
    m_cnt = 0; m_dir = 1'b1; m_tc = 1'b0;
  endtask

  task automatic test_up_wrap();
    int exp_c[4]  = '{6, 9, 3, 6};
    bit exp_tc[4] = '{0, 0, 1, 0};
    i_lo = 8'd3; i_hi = 8'd10; i_step = 8'd3; i_mode = 2'd0; i_sat = 1'b0;
    i_clr = 1'b1; i_en = 1'b1;
    tick();
    i_clr = 1'b0;
    n_checks++; if (o_cnt !== 8'd3) begin n_fail++; $display("FAIL up_wrap_clr: got %0d expected 3", o_cnt); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (o_cnt !== exp_c[k][7:0]) begin n_fail++; $display("FAIL up_wrap_cnt[%0d]: got %0d expected %0d", k, o_cnt, exp_c[k]); end
`ifdef UDCNT_TC_EN
      n_checks++; if (o_tc !== exp_tc[k]) begin n_fail++; $display("FAIL up_wrap_tc[%0d]: got %0d expected %0d", k, o_tc, exp_tc[k]); end
`endif
    end
  endtask

  task automatic test_down_sat();
    int exp_c[5]  = '{5, 3, 3, 3, 3};
    bit exp_tc[5] = '{0, 1, 1, 1, 1};
    i_mode = 2'd1; i_sat = 1'b1; i_load = 1'b1; i_load_val = 8'd8;
    tick();
    i_load = 1'b0;
    n_checks++; if (o_cnt !== 8'd8) begin n_fail++; $display("FAIL down_load: got %0d expected 8", o_cnt); end
    n_checks++; if (o_dir !== 1'b0) begin n_fail++; $display("FAIL down_dir: got %0d expected 0", o_dir); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (o_cnt !== exp_c[k][7:0]) begin n_fail++; $display("FAIL down_sat_cnt[%0d]: got %0d expected %0d", k, o_cnt, exp_c[k]); end
`ifdef UDCNT_TC_EN
      n_checks++; if (o_tc !== exp_tc[k]) begin n_fail++; $display("FAIL down_sat_tc[%0d]: got %0d expected %0d", k, o_tc, exp_tc[k]); end
`endif
    end
  endtask

  task automatic test_bounce();
    int exp_c[9] = '{2, 4, 6, 7, 5, 3, 1, 0, 2};
    bit exp_d[9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    bit exp_t[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    i_lo = 8'd0; i_hi = 8'd7; i_step = 8'd2; i_mode = 2'd2; i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_checks++; if (o_cnt !== exp_c[k][7:0]) begin n_fail++; $display("FAIL bounce_cnt[%0d]: got %0d expected %0d", k, o_cnt, exp_c[k]); end
      n_checks++; if (o_dir !== exp_d[k]) begin n_fail++; $display("FAIL bounce_dir[%0d]: got %0d expected %0d", k, o_dir, exp_d[k]); end
`ifdef UDCNT_TC_EN
      n_checks++; if (o_tc !== exp_t[k]) begin n_fail++; $display("FAIL bounce_tc[%0d]: got %0d expected %0d", k, o_tc, exp_t[k]); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    // From 2 going up: 4, 6, 7 (turns to DOWN), 5.
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (o_dir !== 1'b0 || o_cnt !== 8'd5) begin n_fail++; $display("FAIL rst_mid_pre: got cnt %0d dir %0d expected 5/0", o_cnt, o_dir); end
    #3 i_rst = 1'b1;
    #1;
    n_checks++; if (o_cnt !== 8'd0 || o_dir !== 1'b1) begin n_fail++; $display("FAIL rst_mid_async: got cnt %0d dir %0d expected 0/1", o_cnt, o_dir); end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m_cnt = 0; m_dir = 1'b1; m_tc = 1'b0;
    tick();
    n_checks++; if (o_cnt !== 8'd2 || o_dir !== 1'b1) begin n_fail++; $display("FAIL rst_mid_resume: got cnt %0d dir %0d expected 2/1", o_cnt, o_dir); end
  endtask

  task automatic test_overflow();
    i_en = 1'b0; i_lo = 8'd5; i_hi = 8'd255; i_step = 8'd200; i_mode = 2'd0; i_sat = 1'b0;
    i_load = 1'b1; i_load_val = 8'd100;
    tick();
    i_load = 1'b0; i_en = 1'b1;
    tick();
    n_checks++; if (o_cnt !== 8'd5) begin n_fail++; $display("FAIL overflow_wrap: got %0d expected 5", o_cnt); end
`ifdef UDCNT_TC_EN
    n_checks++; if (o_tc !== 1'b1) begin n_fail++; $display("FAIL overflow_tc: got %0d expected 1", o_tc); end
`endif
    i_sat = 1'b1; i_load = 1'b1;
    tick();
    i_load = 1'b0;
    tick();
    n_checks++; if (o_cnt !== 8'd255) begin n_fail++; $display("FAIL overflow_sat: got %0d expected 255", o_cnt); end
  endtask

  task automatic test_load_clamp();
    i_en = 1'b0; i_lo = 8'd0; i_hi = 8'd200; i_load = 1'b1; i_load_val = 8'd250;
    tick();
    n_checks++; if (o_cnt !== 8'd200) begin n_fail++; $display("FAIL clamp_hi: got %0d expected 200", o_cnt); end
`ifdef UDCNT_TC_EN
    n_checks++; if (o_tc !== 1'b0) begin n_fail++; $display("FAIL clamp_tc: got %0d expected 0", o_tc); end
`endif
    i_lo = 8'd20; i_load_val = 8'd1;
    tick();
    i_load = 1'b0;
    n_checks++; if (o_cnt !== 8'd20) begin n_fail++; $display("FAIL clamp_lo: got %0d expected 20", o_cnt); end
  endtask

  task automatic test_priority();
    i_lo = 8'd4; i_hi = 8'd50; i_step = 8'd1; i_mode = 2'd1; i_sat = 1'b0;
    i_clr = 1'b1; i_load = 1'b1; i_load_val = 8'd30; i_en = 1'b1;
    tick();
    i_clr = 1'b0; i_load = 1'b0;
    n_checks++; if (o_cnt !== 8'd4 || o_dir !== 1'b1) begin n_fail++; $display("FAIL priority: got cnt %0d dir %0d expected 4/1", o_cnt, o_dir); end
`ifdef UDCNT_TC_EN
    n_checks++; if (o_tc !== 1'b0) begin n_fail++; $display("FAIL priority_tc: got %0d expected 0", o_tc); end
`endif
  endtask

  task automatic test_misconfig();
    i_lo = 8'd9; i_hi = 8'd4; i_step = 8'd1; i_mode = 2'd0; i_clr = 1'b1; i_en = 1'b0;
    tick();
    i_clr = 1'b0; i_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (o_cnt !== 8'd9) begin n_fail++; $display("FAIL misconfig_cnt[%0d]: got %0d expected 9", k, o_cnt); end
`ifdef UDCNT_TC_EN
      n_checks++; if (o_tc !== 1'b0) begin n_fail++; $display("FAIL misconfig_tc[%0d]: got %0d expected 0", k, o_tc); end
`endif
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if (k % 16 == 0) begin
        i_lo   = 8'($urandom_range(0, 120));
        i_hi   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(int'(i_lo), 255));
        i_step = ($urandom_range(0, 7) == 0) ? 8'd0 : (($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(1, 20)));
        i_mode = 2'($urandom_range(0, 3));
        i_sat  = 1'($urandom_range(0, 1));
      end
      i_en       = ($urandom_range(0, 99) < 85);
      i_clr      = ($urandom_range(0, 99) < 4);
      i_load     = ($urandom_range(0, 99) < 6);
      i_load_val = 8'($urandom_range(0, 255));
      tick();
      n_checks++; if (o_cnt !== m_cnt[7:0]) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", k, o_cnt, m_cnt); end
      n_checks++; if (o_dir !== m_dir) begin n_fail++; $display("FAIL rand_dir[%0d]: got %0d expected %0d", k, o_dir, m_dir); end
`ifdef UDCNT_TC_EN
      n_checks++; if (o_tc !== m_tc) begin n_fail++; $display("FAIL rand_tc[%0d]: got %0d expected %0d", k, o_tc, m_tc); end
`endif
    end
    i_en = 1'b0; i_clr = 1'b0; i_load = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_bounce();
    test_reset_mid();
    test_overflow();
    test_load_clamp();
    test_priority();
    test_misconfig();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
